// File: rtl/embertrail_dmem.sv
// Dual-lane 16-bit data memory responder for the Embertrail control unit.
// Clears its storage with a sweep after reset, then serves one request per lane per cycle.
module embertrail_dmem #(
  parameter int ADDR_BITS = 8
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic [31:0] iDataAddrBus,
  input  logic [31:0] iDataDataBus,
  input  logic        iData1BusEn,
  input  logic        iData2BusEn,
  input  logic        iDataMem1RW,
  input  logic        iDataMem2RW,
  output logic [31:0] oDataDataBus,
  output logic        oRead1Valid,
  output logic        oRead2Valid,
  output logic        oReady
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  logic [ADDR_BITS-1:0]   sweep_cnt_r;
  logic [15:0]            mem_r [DEPTH];

  logic [ADDR_BITS-1:0]   addr1_s;
  logic [ADDR_BITS-1:0]   addr2_s;
  logic                   wr1_s;
  logic                   wr2_s;
  logic                   rd1_s;
  logic                   rd2_s;
  logic                   sweep_last_s;
  logic                   addr_unused_s;

  // Upper address bits are deliberately discarded so addresses wrap.
  assign addr_unused_s = ^iDataAddrBus;

  // Lane request decode; nothing is acted on until the sweep has finished.
  always_comb begin
    addr1_s      = iDataAddrBus[ADDR_BITS-1:0];
    addr2_s      = iDataAddrBus[16 +: ADDR_BITS];
    sweep_last_s = (sweep_cnt_r == {ADDR_BITS{1'b1}});
    if (state_r == ST_RUN) begin
      wr1_s = iData1BusEn &  iDataMem1RW;
      rd1_s = iData1BusEn & ~iDataMem1RW;
      wr2_s = iData2BusEn &  iDataMem2RW;
      rd2_s = iData2BusEn & ~iDataMem2RW;
    end else begin
      wr1_s = 1'b0;
      rd1_s = 1'b0;
      wr2_s = 1'b0;
      rd2_s = 1'b0;
    end
  end

  // Storage: zeroing sweep in INIT, lane writes in RUN; lane 2 assigned last so it wins a tie.
  always_ff @(posedge iClock) begin
    if (state_r == ST_INIT) begin
      mem_r[sweep_cnt_r] <= 16'h0000;
    end else begin
      if (wr1_s) begin
        mem_r[addr1_s] <= iDataDataBus[15:0];
      end
      if (wr2_s) begin
        mem_r[addr2_s] <= iDataDataBus[31:16];
      end
    end
  end

  // Sweep FSM plus registered read data, valid pulses and ready.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_r      <= ST_INIT;
      sweep_cnt_r  <= {ADDR_BITS{1'b0}};
      oDataDataBus <= 32'h0000_0000;
      oRead1Valid  <= 1'b0;
      oRead2Valid  <= 1'b0;
      oReady       <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          oRead1Valid <= 1'b0;
          oRead2Valid <= 1'b0;
          sweep_cnt_r <= sweep_cnt_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          if (sweep_last_s) begin
            state_r <= ST_RUN;
            oReady  <= 1'b1;
          end else begin
            state_r <= ST_INIT;
            oReady  <= 1'b0;
          end
        end
        ST_RUN: begin
          oReady      <= 1'b1;
          oRead1Valid <= rd1_s;
          oRead2Valid <= rd2_s;
          // Non-blocking reads of mem_r see pre-write contents on a same-cycle collision.
          if (rd1_s) begin
            oDataDataBus[15:0] <= mem_r[addr1_s];
          end
          if (rd2_s) begin
            oDataDataBus[31:16] <= mem_r[addr2_s];
          end
        end
        default: begin
          state_r     <= ST_INIT;
          sweep_cnt_r <= {ADDR_BITS{1'b0}};
          oRead1Valid <= 1'b0;
          oRead2Valid <= 1'b0;
          oReady      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_embertrail_dmem.sv
// Randomized self-checking bench for embertrail_dmem (ADDR_BITS=4) against a word-array model.
module tb_embertrail_dmem;

  localparam int AB    = 4;
  localparam int DEPTH = 16;

  logic        iClock;
  logic        iReset_n;
  logic [31:0] iDataAddrBus;
  logic [31:0] iDataDataBus;
  logic        iData1BusEn;
  logic        iData2BusEn;
  logic        iDataMem1RW;
  logic        iDataMem2RW;
  logic [31:0] oDataDataBus;
  logic        oRead1Valid;
  logic        oRead2Valid;
  logic        oReady;

  embertrail_dmem #(.ADDR_BITS(AB)) dut (
    .iClock       (iClock),
    .iReset_n     (iReset_n),
    .iDataAddrBus (iDataAddrBus),
    .iDataDataBus (iDataDataBus),
    .iData1BusEn  (iData1BusEn),
    .iData2BusEn  (iData2BusEn),
    .iDataMem1RW  (iDataMem1RW),
    .iDataMem2RW  (iDataMem2RW),
    .oDataDataBus (oDataDataBus),
    .oRead1Valid  (oRead1Valid),
    .oRead2Valid  (oRead2Valid),
    .oReady       (oReady)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array plus edges counted since reset release.
  logic [15:0] ref_mem [DEPTH];
  int          edges;
  logic [31:0] ref_data;
  logic        ref_v1;
  logic        ref_v2;
  logic        ref_ready;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    edges     = 0;
    ref_data  = 32'h0;
    ref_v1    = 1'b0;
    ref_v2    = 1'b0;
    ref_ready = 1'b0;
  endtask

  task automatic idle_inputs();
    iDataAddrBus = 32'h0;
    iDataDataBus = 32'h0;
    iData1BusEn  = 1'b0;
    iData2BusEn  = 1'b0;
    iDataMem1RW  = 1'b0;
    iDataMem2RW  = 1'b0;
  endtask

  // One clock: drive, advance model, then compare every output.
  task automatic step(input logic e1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                      input logic e2, input logic w2, input logic [15:0] a2, input logic [15:0] d2);
    logic [15:0] old1, old2;
    iData1BusEn  = e1;
    iDataMem1RW  = w1;
    iData2BusEn  = e2;
    iDataMem2RW  = w2;
    iDataAddrBus = {a2, a1};
    iDataDataBus = {d2, d1};
    @(posedge iClock);
    if (edges >= DEPTH) begin
      old1   = ref_mem[a1 % DEPTH];
      old2   = ref_mem[a2 % DEPTH];
      ref_v1 = e1 && !w1;
      ref_v2 = e2 && !w2;
      if (ref_v1) ref_data[15:0]  = old1;
      if (ref_v2) ref_data[31:16] = old2;
      if (e1 && w1) ref_mem[a1 % DEPTH] = d1;
      if (e2 && w2) ref_mem[a2 % DEPTH] = d2;
    end else begin
      ref_v1 = 1'b0;
      ref_v2 = 1'b0;
    end
    edges++;
    ref_ready = (edges >= DEPTH);
    #1;
    check_val("data",  oDataDataBus, ref_data);
    check_val("v1",    {31'b0, oRead1Valid}, {31'b0, ref_v1});
    check_val("v2",    {31'b0, oRead2Valid}, {31'b0, ref_v2});
    check_val("ready", {31'b0, oReady}, {31'b0, ref_ready});
  endtask

  task automatic rand_step(input logic force_req);
    logic [15:0] a1, a2;
    a1 = {$urandom_range(0, 4095) % 16'h1000, 4'h0} | 16'($urandom_range(0, 5));
    a2 = {$urandom_range(0, 4095) % 16'h1000, 4'h0} | 16'($urandom_range(0, 5));
    step(force_req | 1'($urandom_range(0, 3) != 0), 1'($urandom), a1, 16'($urandom),
         force_req | 1'($urandom_range(0, 3) != 0), 1'($urandom), a2, 16'($urandom));
  endtask

  // Asynchronous reset pulse, then the full sweep with requests thrown at it.
  task automatic reset_and_sweep();
    iReset_n = 1'b0;
    #1;
    check_val("rst_data",  oDataDataBus, 32'h0);
    check_val("rst_ready", {31'b0, oReady}, 32'h0);
    check_val("rst_v",     {30'b0, oRead2Valid, oRead1Valid}, 32'h0);
    @(posedge iClock);
    #1;
    iReset_n = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH; i++) rand_step(1'b1);
    check_val("ready_after_sweep", {31'b0, oReady}, 32'h1);
  endtask

  initial begin
    iReset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_val("por_data",  oDataDataBus, 32'h0);
    check_val("por_ready", {31'b0, oReady}, 32'h0);
    @(posedge iClock);
    #1;
    iReset_n = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("ready_low_15", {31'b0, oReady}, 32'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("ready_high_16", {31'b0, oReady}, 32'h1);

    // Swept storage reads zero; put non-zero data on the bus first.
    step(1'b1, 1'b1, 16'h0009, 16'h0F0F, 1'b1, 1'b1, 16'h000A, 16'hF0F0);
    step(1'b1, 1'b0, 16'h0007, 16'h0, 1'b1, 1'b0, 16'h000F, 16'h0);
    check_val("zero_after_sweep", oDataDataBus, 32'h0);

    step(1'b1, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("beef", {16'h0, oDataDataBus[15:0]}, 32'h0000_BEEF);
    check_val("beef_v1", {31'b0, oRead1Valid}, 32'h1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("beef_pulse_end", {31'b0, oRead1Valid}, 32'h0);
    check_val("beef_hold", {16'h0, oDataDataBus[15:0]}, 32'h0000_BEEF);

    step(1'b1, 1'b1, 16'h0005, 16'h1111, 1'b1, 1'b1, 16'h0005, 16'h2222);
    step(1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("lane2_wins", {16'h0, oDataDataBus[15:0]}, 32'h0000_2222);

    step(1'b1, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 1'b1, 16'h0005, 16'h5555);
    check_val("rd_before_wr", {16'h0, oDataDataBus[15:0]}, 32'h0000_AAAA);
    step(1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("rd_after_wr", {16'h0, oDataDataBus[15:0]}, 32'h0000_5555);

    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0013, 16'h1234);
    step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b1, 1'b0, 16'h0003, 16'h0);
    check_val("wrap", oDataDataBus, 32'h1234_1234);

    for (int i = 0; i < 1500; i++) rand_step(1'b0);

    step(1'b1, 1'b1, 16'h0002, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0);
    reset_and_sweep();
    step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b1, 1'b0, 16'h0102, 16'h0);
    check_val("cleared_after_reset", oDataDataBus, 32'h0);

    for (int i = 0; i < 500; i++) rand_step(1'b0);

    // Reset part-way through a sweep restarts it from the beginning.
    iReset_n = 1'b0;
    @(posedge iClock);
    #1;
    iReset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 7; i++) rand_step(1'b1);
    reset_and_sweep();
    for (int i = 0; i < 300; i++) rand_step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
